rgb_led_driver: RTL
===================

RGB_LED_DRIVER -- requirements
Module: rgb_led_driver

Interface
REQ-001 Parameter PWM_BITS, default 8, PWM counter width; the period is 2^PWM_BITS cycles.
REQ-002 Parameter BLINK_HALF, default 25_000_000, cycles per blink phase (ON or OFF).
REQ-003 Parameter NUM_BLINKS, default 3, ON/OFF pairs per colour-change flash.
REQ-004 Port list: one clock; reset is synchronous and active-low.
REQ-005 clock  in  1  system clock; all logic on the rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 RGB_estado  in  3  requested colour {R,G,B}; 3'b000 means off.
REQ-008 brilho  in  2  brightness level, sampled every cycle.
REQ-009 habilita  in  1  driver enable; 0 forces all LEDs off.
REQ-010 led_r, led_g, led_b  out  1 each  registered LED drive outputs, active-high.
REQ-011 db_piscando  out  1  registered debug flag; 1 while the FSM is in a blink state.

Function
REQ-012 FSM states: IDLE, PISCA_ON, PISCA_OFF, ESTAVEL.
REQ-013 Register cor_atual holds the colour being displayed.
REQ-014 On any edge where habilita=1 and RGB_estado != cor_atual: load cor_atual <= RGB_estado, clear the phase counter and blink counter, and go to PISCA_ON (nonzero colour) or IDLE (3'b000); this applies from every state, so a change mid-blink restarts the flash.
REQ-015 PISCA_ON -> PISCA_OFF after BLINK_HALF cycles in state.
REQ-016 PISCA_OFF -> PISCA_ON after BLINK_HALF cycles; after the NUM_BLINKS-th OFF phase, go to ESTAVEL instead.
REQ-017 ESTAVEL and IDLE hold until a colour change (REQ-014) or habilita=0.
REQ-018 habilita=0: next state IDLE and cor_atual <= 3'b000, so re-enabling with a nonzero colour triggers a fresh flash.
REQ-019 A free-running PWM_BITS counter wraps from 2^PWM_BITS-1 to 0 and never stops.
REQ-020 Duty by brilho: 00 -> 1/8, 01 -> 1/4, 10 -> 1/2, 11 -> always on; "on" when pwm_cnt < duty threshold (32/64/128 for PWM_BITS=8).
REQ-021 led_* <= cor_atual bit AND (state is PISCA_ON or ESTAVEL) AND PWM on; 0 in IDLE and PISCA_OFF.
REQ-022 Outputs are registered: one cycle of latency from state/cor_atual to led_* and db_piscando.
REQ-023 A brilho change takes effect on the next PWM comparison and never restarts the flash.
REQ-024 The phase counter must be wide enough for BLINK_HALF-1 and must never wrap within a phase.

Reset
REQ-025 reset_n=0 at a rising edge: state=IDLE; cor_atual, PWM counter, phase counter, blink counter = 0; led_r/g/b=0; db_piscando=0.
REQ-026 Reset overrides all inputs, including a mid-flash reset.
REQ-027 After reset release, a nonzero RGB_estado is treated as a colour change (REQ-014).

Structure
REQ-028 The shared package holds: the FSM state encoding, colour constants (RED=100, GREEN=010, BLUE=001, CYAN=011, PURPLE=101, WHITE=111), and the brilho-to-duty table.
REQ-029 The PWM counter and comparator form one sub-module, pwm_gerador (inputs: clock, reset_n, brilho; output: pwm_on).
REQ-030 Target implementation size: 120-400 lines.

Verification (BLINK_HALF=4, NUM_BLINKS=3, brilho=11, habilita=1 unless stated)
REQ-031 Reset: hold reset_n=0 for 2 cycles with RGB_estado=100 -> led_*=000 and db_piscando=0 throughout; after release, led_r starts blinking.
REQ-032 Flash: RGB_estado 000->100 seen at edge 0 -> led_r=1 for cycles 2-5, 0 for 6-9, repeated 3 times; then led_r=1 steady from cycle 26; db_piscando=1 for cycles 2-25.
REQ-033 Mid-blink change: 100->011 during the 2nd ON phase -> led_r=0 from the next output cycle; led_g and led_b complete 3 full blinks, then go steady.
REQ-034 PWM: steady GREEN, brilho=01 -> led_g=1 for exactly 64 of every 256 cycles; brilho=00 -> 32; brilho=11 -> 256.
REQ-035 Enable: habilita=0 while in ESTAVEL -> led_*=000 one cycle later; habilita=1 with RGB_estado=001 -> full 3-blink flash on led_b.
REQ-036 Off colour: RGB_estado 101->000 -> state IDLE, led_*=000, no flash, db_piscando=0.

Source files
------------

// File: rtl/rgb_led_driver_pkg.sv
// Shared definitions for the RGB LED driver: FSM encoding, colour codes, brightness table.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package rgb_led_driver_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PISCA_ON  = 2'd1,
      ST_PISCA_OFF = 2'd2,
      ST_ESTAVEL   = 2'd3
   } state_t;

   // Colour codes, bit order {R,G,B}
   localparam logic [2:0] COR_OFF    = 3'b000;
   localparam logic [2:0] COR_RED    = 3'b100;
   localparam logic [2:0] COR_GREEN  = 3'b010;
   localparam logic [2:0] COR_BLUE   = 3'b001;
   localparam logic [2:0] COR_CYAN   = 3'b011;
   localparam logic [2:0] COR_PURPLE = 3'b101;
   localparam logic [2:0] COR_WHITE  = 3'b111;

   // Brightness table: the duty threshold is the full PWM period shifted right
   // by this amount, giving 1/8, 1/4, 1/2 and full period (always on).
   function automatic int unsigned duty_shift(input logic [1:0] brilho);
      case (brilho)
         2'b00:   return 3;
         2'b01:   return 2;
         2'b10:   return 1;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/rgb_led_driver_if.sv
// Bundles the colour request, brightness, enable and the LED/debug outputs of the driver.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level-sampled every cycle.
//   master: drives RGB_estado, brilho, habilita; observes led_r/g/b, db_piscando
//   slave : the driver side
interface rgb_led_driver_if;

   logic [2:0] RGB_estado;
   logic [1:0] brilho;
   logic       habilita;
   logic       led_r;
   logic       led_g;
   logic       led_b;
   logic       db_piscando;

   modport master (
      output RGB_estado, brilho, habilita,
      input  led_r, led_g, led_b, db_piscando
   );

   modport slave (
      input  RGB_estado, brilho, habilita,
      output led_r, led_g, led_b, db_piscando
   );

endinterface

// File: rtl/rgb_led_driver_pwm_gerador.sv
// Free-running PWM counter plus brightness comparator.
// Latency: pwm_on is combinational from the counter register and brilho.
// Backpressure: none; the counter never stops.
//   clock, reset_n : clock and synchronous active-low reset
//   brilho         : 2-bit brightness level
//   pwm_on         : high while the counter is below the duty threshold
module pwm_gerador
   import rgb_led_driver_pkg::*;
#(
   parameter int PWM_BITS = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:0] brilho,
   output logic       pwm_on
);

   logic [PWM_BITS-1:0] r_cnt;
   logic [PWM_BITS:0]   w_thresh;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + PWM_BITS'(1);
      end
   end

   // One extra bit so a shift of zero yields 2^PWM_BITS, above every count.
   always_comb begin
      w_thresh = {1'b1, {PWM_BITS{1'b0}}} >> duty_shift(brilho);
   end

   assign pwm_on = ({1'b0, r_cnt} < w_thresh);

endmodule

// File: rtl/rgb_led_driver.sv
// RGB LED driver: flashes NUM_BLINKS times on each colour change, then shows the colour steadily with PWM dimming.
// Latency: one cycle from state/colour register to led_r/g/b and db_piscando.
// Backpressure: none; inputs are sampled every cycle.
//   clock, reset_n : clock and synchronous active-low reset
//   bus            : RGB_estado, brilho, habilita in; led_r/g/b, db_piscando out
module rgb_led_driver
   import rgb_led_driver_pkg::*;
#(
   parameter int PWM_BITS   = 8,
   parameter int BLINK_HALF = 25_000_000,
   parameter int NUM_BLINKS = 3
) (
   input  logic             clock,
   input  logic             reset_n,
   rgb_led_driver_if.slave  bus
);

   localparam int PH_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int BL_W = (NUM_BLINKS > 1) ? $clog2(NUM_BLINKS) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(BLINK_HALF - 1);
   localparam logic [BL_W-1:0] BL_LAST = BL_W'(NUM_BLINKS - 1);

   state_t          r_state;
   state_t          w_next_state;
   logic [2:0]      r_cor;
   logic [2:0]      w_next_cor;
   logic [PH_W-1:0] r_phase;
   logic [PH_W-1:0] w_next_phase;
   logic [BL_W-1:0] r_blink;
   logic [BL_W-1:0] w_next_blink;
   logic [2:0]      r_led;
   logic            r_db;
   logic            w_pwm_on;
   logic            w_phase_end;
   logic            w_show;

   pwm_gerador #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm (
      .clock   (clock),
      .reset_n (reset_n),
      .brilho  (bus.brilho),
      .pwm_on  (w_pwm_on)
   );

   assign w_phase_end = (r_phase == PH_LAST);
   assign w_show      = (r_state == ST_PISCA_ON) || (r_state == ST_ESTAVEL);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cor   <= COR_OFF;
         r_phase <= '0;
         r_blink <= '0;
         r_led   <= 3'b000;
         r_db    <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_cor   <= w_next_cor;
         r_phase <= w_next_phase;
         r_blink <= w_next_blink;
         r_led   <= r_cor & {3{w_show & w_pwm_on}};
         r_db    <= (r_state == ST_PISCA_ON) || (r_state == ST_PISCA_OFF);
      end
   end

   // Disable and colour change take priority over phase timing, from any state,
   // so a new colour mid-flash restarts the flash from its first ON phase.
   always_comb begin
      w_next_state = r_state;
      w_next_cor   = r_cor;
      w_next_phase = r_phase;
      w_next_blink = r_blink;
      if (!bus.habilita) begin
         // Clearing the colour makes the next enable look like a change.
         w_next_state = ST_IDLE;
         w_next_cor   = COR_OFF;
         w_next_phase = '0;
         w_next_blink = '0;
      end else if (bus.RGB_estado != r_cor) begin
         w_next_cor   = bus.RGB_estado;
         w_next_phase = '0;
         w_next_blink = '0;
         w_next_state = (bus.RGB_estado == COR_OFF) ? ST_IDLE : ST_PISCA_ON;
      end else begin
         case (r_state)
            ST_PISCA_ON: begin
               if (w_phase_end) begin
                  w_next_state = ST_PISCA_OFF;
                  w_next_phase = '0;
               end else begin
                  w_next_phase = r_phase + PH_W'(1);
               end
            end
            ST_PISCA_OFF: begin
               if (w_phase_end) begin
                  w_next_phase = '0;
                  if (r_blink == BL_LAST) begin
                     w_next_state = ST_ESTAVEL;
                     w_next_blink = '0;
                  end else begin
                     w_next_state = ST_PISCA_ON;
                     w_next_blink = r_blink + BL_W'(1);
                  end
               end else begin
                  w_next_phase = r_phase + PH_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.led_r       = r_led[2];
   assign bus.led_g       = r_led[1];
   assign bus.led_b       = r_led[0];
   assign bus.db_piscando = r_db;

endmodule
